// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor datapath.
package sub_pkg;

    localparam int unsigned WIDTH = 17;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor: diff = a - b - bin.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    // Borrow out when a is smaller than b plus the incoming borrow.
    always_comb begin
        diff = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_sub17.sv
// Bit-serial two's-complement subtractor, LSB first, one slice per clock.
module serial_sub17
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = sub_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             sign_a;
    logic             sign_b;
    logic             slice_diff;
    logic             slice_bout;

    full_subtractor u_slice (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .bin  (borrow),
        .diff (slice_diff),
        .bout (slice_bout)
    );

    // FSM, operand shifters, borrow flop and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            d      <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a   <= a;
                        op_b   <= b;
                        sign_a <= a[WIDTH-1];
                        sign_b <= b[WIDTH-1];
                        d      <= '0;
                        bout   <= 1'b0;
                        ovf    <= 1'b0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    d      <= {slice_diff, d[WIDTH-1:1]};
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    borrow <= slice_bout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        // The last slice produces the sign bit of D, so
                        // overflow is resolved from it directly.
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        bout  <= slice_bout;
                        ovf   <= (sign_a != sign_b) && (slice_diff != sign_a);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub17.sv
// Directed self-checking bench for serial_sub17.
module tb_serial_sub17;

    localparam int unsigned W = 17;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;

    int total;
    int bad;
    int overlap;

    serial_sub17 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // busy and done must never be seen high together.
    always @(negedge clk) begin
        if (rst_n && busy && done) overlap++;
    end

    // Advance one clock; inputs change and outputs are read 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Clock until done rises, returning the number of edges taken (bounded).
    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!done && cycles < 40);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        a = 17'h00005;
        b = 17'h00003;
        step();
        step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: busy=%b done=%b required busy=0 done=0", busy, done);
        end
        total++;
        if (d !== 17'h0 || bout !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_data: d=%h bout=%b ovf=%b required d=00000 bout=0 ovf=0", d, bout, ovf);
        end
        start = 1'b0;
        rst_n = 1'b1;
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_nostart: busy=%b required 0", busy);
        end
    endtask

    task automatic test_basic();
        int cyc;
        a = 17'h06667;
        b = 17'h18001;
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy: busy=%b required 1", busy);
        end
        wait_done(cyc);
        total++;
        if (cyc != 17) begin
            bad++;
            $display("FAIL basic_latency: cycles=%0d required 17", cyc);
        end
        total++;
        if (d !== 17'h0E666 || bout !== 1'b1 || ovf !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_result: d=%h bout=%b ovf=%b busy=%b required d=0e666 bout=1 ovf=0 busy=0", d, bout, ovf, busy);
        end
        step();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL basic_pulse: done=%b required 0", done);
        end
        step();
        step();
        total++;
        if (d !== 17'h0E666 || bout !== 1'b1 || ovf !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_hold: d=%h bout=%b ovf=%b busy=%b required d=0e666 bout=1 ovf=0 busy=0", d, bout, ovf, busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        a = 17'h00005;
        b = 17'h00003;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(cyc);
        total++;
        if (cyc != 17 || d !== 17'h00002 || bout !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first: cycles=%0d d=%h bout=%b ovf=%b required cycles=17 d=00002 bout=0 ovf=0", cyc, d, bout, ovf);
        end
        // Start presented during the DONE cycle.
        a = 17'h00000;
        b = 17'h00001;
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || d !== 17'h0) begin
            bad++;
            $display("FAIL b2b_accept: busy=%b done=%b d=%h required busy=1 done=0 d=00000", busy, done, d);
        end
        wait_done(cyc);
        total++;
        if (cyc != 17 || d !== 17'h1FFFF || bout !== 1'b1 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: cycles=%0d d=%h bout=%b ovf=%b required cycles=17 d=1ffff bout=1 ovf=0", cyc, d, bout, ovf);
        end
        step();
    endtask

    task automatic test_overflow();
        int cyc;
        a = 17'h10000;
        b = 17'h00001;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(cyc);
        total++;
        if (cyc != 17 || d !== 17'h0FFFF || bout !== 1'b0 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_neg: cycles=%0d d=%h bout=%b ovf=%b required cycles=17 d=0ffff bout=0 ovf=1", cyc, d, bout, ovf);
        end
        step();
        a = 17'h0FFFF;
        b = 17'h1FFFF;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(cyc);
        total++;
        if (cyc != 17 || d !== 17'h10000 || bout !== 1'b1 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_pos: cycles=%0d d=%h bout=%b ovf=%b required cycles=17 d=10000 bout=1 ovf=1", cyc, d, bout, ovf);
        end
        step();
    endtask

    task automatic test_ignore_start();
        int cyc;
        a = 17'h00100;
        b = 17'h00001;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            if (cyc == 3 || cyc == 10) begin
                a = 17'h1FFFF;
                b = 17'h00000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        total++;
        if (cyc != 17 || d !== 17'h000FF || bout !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL ignore_busy: cycles=%0d d=%h bout=%b ovf=%b required cycles=17 d=000ff bout=0 ovf=0", cyc, d, bout, ovf);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int done_seen;
        a = 17'h00007;
        b = 17'h00002;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || d !== 17'h0 || bout !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL abort_state: busy=%b done=%b d=%h bout=%b ovf=%b required all 0", busy, done, d, bout, ovf);
        end
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        total++;
        if (done_seen != 0) begin
            bad++;
            $display("FAIL abort_quiet: active_cycles=%0d required 0", done_seen);
        end
        a = 17'h00009;
        b = 17'h0000A;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(cyc);
        total++;
        if (cyc != 17 || d !== 17'h1FFFF || bout !== 1'b1 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL abort_restart: cycles=%0d d=%h bout=%b ovf=%b required cycles=17 d=1ffff bout=1 ovf=0", cyc, d, bout, ovf);
        end
        step();
    endtask

    task automatic test_no_overlap();
        total++;
        if (overlap != 0) begin
            bad++;
            $display("FAIL busy_done_overlap: count=%0d required 0", overlap);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        overlap = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_ignore_start();
        test_reset_mid_run();
        test_no_overlap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
